regfile_writeback_arbiter: RTL and testbench
============================================

# regfile_writeback_arbiter

Serialises register writebacks from the single-cycle ALU path and the multi-cycle multiply/divide unit onto the register file's single write port (`ctrl_writeEnable` / `ctrl_writeReg` / `data_writeReg`). It buffers multdiv results in a small FIFO and prevents starvation with an age limit. It also forwards pending write data to the decode stage, because the register file returns high-Z on a read of a register being written in the same cycle.

## Interface
- `DEPTH`, 2: multdiv result FIFO entries; power of two, ≥2.
- `STARVE_LIMIT`, 4: consecutive cycles the FIFO head may be blocked by the ALU before it is forced out.

Ports:
- `clock`  in  1  system clock, rising edge.
- `ctrl_reset`  in  1  asynchronous, active-high reset.
- `alu_valid`  in  1  ALU result present this cycle.
- `alu_rd`  in  5  ALU destination register.
- `alu_data`  in  32  ALU result.
- `alu_stall`  out  1  combinational; ALU result not accepted this cycle, upstream holds it.
- `md_valid`  in  1  multdiv result present.
- `md_rd`  in  5  multdiv destination register.
- `md_data`  in  32  multdiv result.
- `md_ready`  out  1  FIFO not full; a push happens on `md_valid && md_ready`.
- `ctrl_writeEnable`  out  1  registered; drives register file write enable.
- `ctrl_writeReg`  out  5  registered write address.
- `data_writeReg`  out  32  registered write data.
- `fwd_regA`, `fwd_regB`  in  5 each  decode read addresses.
- `fwd_hitA`, `fwd_hitB`  out  1 each  pending write to that register exists.
- `fwd_dataA`, `fwd_dataB`  out  32 each  forwarded data; 0 when no hit.
- `pending_count`  out  clog2(DEPTH)+1  FIFO occupancy.

## Operation
- **Write slot selection**, evaluated every cycle and loaded at the clock edge:
  - Forced pop: if the FIFO is non-empty and the starve counter equals `STARVE_LIMIT`, pop the head into the write slot and assert `alu_stall`. The ALU input is ignored that cycle.
  - Else, if `alu_valid && alu_rd != 0`, load the ALU result.
  - Else, if the FIFO is non-empty, pop the head.
  - Else, `ctrl_writeEnable` = 0. `ctrl_writeReg` and `data_writeReg` hold their last values.
- **r0:** an ALU result with `alu_rd == 0` is consumed without writing and never stalls. An `md_rd == 0` push is accepted (handshake completes) but not enqueued.
- **FIFO:** circular buffer with read/write pointers that wrap at `DEPTH`.
  - `md_ready` = (count < `DEPTH`), computed from registered count only. A pop in the same cycle does not free a slot for a same-cycle push.
  - Simultaneous push and pop when non-full leaves count unchanged.
- **Starve counter:**
  - Increments each cycle the FIFO is non-empty and the head is not popped.
  - Clears on any pop or when the FIFO is empty.
  - Saturates at `STARVE_LIMIT`.
- **Forwarding** (r0 never hits). Priority order:
  1. Youngest FIFO entry with matching rd.
  2. Older FIFO entries, in age order.
  3. The write-slot register, when `ctrl_writeEnable` = 1 and its address matches.
- Decode interlock guarantees no WAW between ALU and multdiv results. The priority order above is still mandatory.

## Timing
- ALU result at edge N appears on the write port after edge N, i.e. written to the register file at edge N+1.
- A multdiv push at edge N is poppable at edge N+1 at the earliest: `ctrl_writeEnable` high after N+1.
- `alu_stall` and forwarding outputs are combinational from current state and inputs. Zero latency.
- `ctrl_reset` asserted at any time, including mid-write or with a full FIFO:
  - FIFO is emptied and pointers, count and starve counter are zeroed.
  - `ctrl_writeEnable`, `ctrl_writeReg` and `data_writeReg` are cleared to 0.
  - Reset values: `alu_stall` 0, `md_ready` 1, `pending_count` 0, `fwd_hit*` 0, `fwd_data*` 0.
  - Pushes during reset are discarded.

## Configuration
- `WB_FORWARD_EN` defined: the forwarding comparators and mux are compiled in, as described above.
- `WB_FORWARD_EN` undefined: `fwd_hitA`/`fwd_hitB` are tied to 0 and `fwd_dataA`/`fwd_dataB` to 0. Decode must stall on all pending writes. Write arbitration is unchanged.

## Test plan
- **ALU single write:** after reset, `alu_valid`=1, rd=5, data=0xDEADBEEF for one cycle -> next cycle `ctrl_writeEnable`=1, `ctrl_writeReg`=5, `data_writeReg`=0xDEADBEEF, then `ctrl_writeEnable`=0.
- **FIFO fill:** 2 md pushes (rd=3, 0x11; rd=4, 0x22) while the ALU is continuously valid with rd=7 -> `md_ready`=0 after the second push.
- **Starvation:** same setup as FIFO fill -> after 4 blocked cycles `alu_stall`=1 and a write of r3=0x11 occurs. The starve counter restarts, and r4=0x22 is forced 4 cycles later.
- **r0 handling:** `alu_rd`=0 and `md_rd`=0 pushes -> no write-port activity, `pending_count` stays 0, `alu_stall` never set.
- **Forwarding:** FIFO holds r9=0xA then r9=0xB, `fwd_regA`=9 -> `fwd_hitA`=1, `fwd_dataA`=0xB. With `fwd_regB`=0 -> `fwd_hitB`=0. With `WB_FORWARD_EN` undefined, both hits are 0.
- **Reset mid-operation:** FIFO full and write in flight, pulse `ctrl_reset` between edges -> immediately `ctrl_writeEnable`=0, `pending_count`=0, `md_ready`=1. No queued write appears afterward.

Source files
------------

// File: rtl/regfile_writeback_arbiter_if.sv
// Writeback arbiter bus: ALU and multdiv result inputs, register file write port,
// decode forwarding lookups and FIFO occupancy. DEPTH must match the arbiter instance.
interface regfile_writeback_arbiter_if #(
   parameter int DEPTH = 2
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          alu_valid;
   logic [4:0]    alu_rd;
   logic [31:0]   alu_data;
   logic          alu_stall;
   logic          md_valid;
   logic [4:0]    md_rd;
   logic [31:0]   md_data;
   logic          md_ready;
   logic          ctrl_writeEnable;
   logic [4:0]    ctrl_writeReg;
   logic [31:0]   data_writeReg;
   logic [4:0]    fwd_regA;
   logic [4:0]    fwd_regB;
   logic          fwd_hitA;
   logic          fwd_hitB;
   logic [31:0]   fwd_dataA;
   logic [31:0]   fwd_dataB;
   logic [CW-1:0] pending_count;

   modport master (
      output alu_valid, alu_rd, alu_data, md_valid, md_rd, md_data, fwd_regA, fwd_regB,
      input  alu_stall, md_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg,
      input  fwd_hitA, fwd_hitB, fwd_dataA, fwd_dataB, pending_count
   );

   modport slave (
      input  alu_valid, alu_rd, alu_data, md_valid, md_rd, md_data, fwd_regA, fwd_regB,
      output alu_stall, md_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg,
      output fwd_hitA, fwd_hitB, fwd_dataA, fwd_dataB, pending_count
   );
endinterface

// File: rtl/regfile_writeback_arbiter.sv
// Merges ALU and multdiv writebacks onto one registered write port (1 cycle); multdiv is
// buffered with md_ready backpressure, ALU stalls only on a starvation pop. WB_FORWARD_EN adds forwarding.
module regfile_writeback_arbiter #(
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                        clock,
   input  logic                        ctrl_reset,
   regfile_writeback_arbiter_if.slave  wb
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } entry_t;

   entry_t        mem_q [DEPTH];
   entry_t        mem_d [DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [SW-1:0] starve_q, starve_d;
   logic          we_q, we_d;
   logic [4:0]    wreg_q, wreg_d;
   logic [31:0]   wdata_q, wdata_d;

   logic   fifo_empty, forced_pop, alu_wr, push, pop;
   entry_t head;

   assign fifo_empty = (count_q == '0);
   assign forced_pop = !fifo_empty && (starve_q == SW'(STARVE_LIMIT));
   assign alu_wr     = wb.alu_valid && (wb.alu_rd != 5'd0);
   assign pop        = forced_pop || (!alu_wr && !fifo_empty);
   // Readiness comes from registered count only, so a same-cycle pop never frees a slot.
   assign push       = wb.md_valid && wb.md_ready && (wb.md_rd != 5'd0);
   assign head       = mem_q[rd_ptr_q];

   assign wb.md_ready         = (count_q < CW'(DEPTH));
   assign wb.alu_stall        = forced_pop && alu_wr;
   assign wb.pending_count    = count_q;
   assign wb.ctrl_writeEnable = we_q;
   assign wb.ctrl_writeReg    = wreg_q;
   assign wb.data_writeReg    = wdata_q;

   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      starve_d = starve_q;
      we_d     = 1'b0;
      wreg_d   = wreg_q;
      wdata_d  = wdata_q;
      if (push) begin
         mem_d[wr_ptr_q] = '{rd: wb.md_rd, data: wb.md_data};
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
         we_d     = 1'b1;
         wreg_d   = head.rd;
         wdata_d  = head.data;
      end else if (alu_wr) begin
         we_d    = 1'b1;
         wreg_d  = wb.alu_rd;
         wdata_d = wb.alu_data;
      end
      count_d = count_q + CW'(push) - CW'(pop);
      if (pop || fifo_empty) begin
         starve_d = '0;
      end else if (starve_q != SW'(STARVE_LIMIT)) begin
         starve_d = starve_q + SW'(1);
      end
   end

   always_ff @(posedge clock or posedge ctrl_reset) begin
      if (ctrl_reset) begin
         mem_q    <= '{default: '0};
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         starve_q <= '0;
         we_q     <= 1'b0;
         wreg_q   <= '0;
         wdata_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         starve_q <= starve_d;
         we_q     <= we_d;
         wreg_q   <= wreg_d;
         wdata_q  <= wdata_d;
      end
   end

`ifdef WB_FORWARD_EN
   logic [PW-1:0] fwd_idx;
   logic          hit_a, hit_b;
   logic [31:0]   dat_a, dat_b;

   // Walk the FIFO oldest to youngest so the youngest match wins; the write slot is the fallback.
   always_comb begin
      fwd_idx = rd_ptr_q;
      hit_a   = we_q && (wb.fwd_regA != 5'd0) && (wreg_q == wb.fwd_regA);
      hit_b   = we_q && (wb.fwd_regB != 5'd0) && (wreg_q == wb.fwd_regB);
      dat_a   = hit_a ? wdata_q : 32'd0;
      dat_b   = hit_b ? wdata_q : 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
         fwd_idx = rd_ptr_q + PW'(i);
         if ((CW'(i) < count_q) && (wb.fwd_regA != 5'd0) && (mem_q[fwd_idx].rd == wb.fwd_regA)) begin
            hit_a = 1'b1;
            dat_a = mem_q[fwd_idx].data;
         end
         if ((CW'(i) < count_q) && (wb.fwd_regB != 5'd0) && (mem_q[fwd_idx].rd == wb.fwd_regB)) begin
            hit_b = 1'b1;
            dat_b = mem_q[fwd_idx].data;
         end
      end
   end

   assign wb.fwd_hitA  = hit_a;
   assign wb.fwd_hitB  = hit_b;
   assign wb.fwd_dataA = dat_a;
   assign wb.fwd_dataB = dat_b;
`else
   logic unused_fwd;
   assign unused_fwd   = ^{wb.fwd_regA, wb.fwd_regB};
   assign wb.fwd_hitA  = 1'b0;
   assign wb.fwd_hitB  = 1'b0;
   assign wb.fwd_dataA = 32'd0;
   assign wb.fwd_dataB = 32'd0;
`endif
endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Directed vector bench for regfile_writeback_arbiter: per-cycle table plus a mid-operation reset sequence.
module tb_regfile_writeback_arbiter;
`ifdef WB_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic clock = 1'b0;
   logic ctrl_reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   regfile_writeback_arbiter_if #(.DEPTH(2)) wb ();

   regfile_writeback_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
      .clock      (clock),
      .ctrl_reset (ctrl_reset),
      .wb         (wb)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        av;  logic [4:0] ard; logic [31:0] adat;
      logic        mv;  logic [4:0] mrd; logic [31:0] mdat;
      logic [4:0]  fa;  logic [4:0] fb;
      logic        stall; logic rdy; logic [1:0] cnt;
      logic        we;  logic [4:0] wreg; logic [31:0] wdat;
      logic        ha;  logic [31:0] da; logic hb; logic [31:0] db;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t v(logic av, logic [4:0] ard, logic [31:0] adat,
                              logic mv, logic [4:0] mrd, logic [31:0] mdat,
                              logic [4:0] fa, logic [4:0] fb,
                              logic stall, logic rdy, logic [1:0] cnt,
                              logic we, logic [4:0] wreg, logic [31:0] wdat,
                              logic ha, logic [31:0] da, logic hb, logic [31:0] db);
      vec_t r;
      r.av = av; r.ard = ard; r.adat = adat; r.mv = mv; r.mrd = mrd; r.mdat = mdat;
      r.fa = fa; r.fb = fb; r.stall = stall; r.rdy = rdy; r.cnt = cnt;
      r.we = we; r.wreg = wreg; r.wdat = wdat; r.ha = ha; r.da = da; r.hb = hb; r.db = db;
      return r;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                        input logic mv, input logic [4:0] mrd, input logic [31:0] mdat,
                        input logic [4:0] fa, input logic [4:0] fb);
      wb.alu_valid = av; wb.alu_rd = ard; wb.alu_data = adat;
      wb.md_valid  = mv; wb.md_rd  = mrd; wb.md_data  = mdat;
      wb.fwd_regA  = fa; wb.fwd_regB = fb;
   endtask

   initial begin
      vec_t t;
      drive(0, 0, 0, 0, 0, 0, 0, 0);

      //     av rd  adat          mv rd mdat   fa fb  st rdy cnt we wr wdat          ha da            hb db
      vq.push_back(v(0, 0, 0,            0, 0, 0,    0, 0,  0, 1, 0,  0, 0, 0,            0, 0,            0, 0));
      vq.push_back(v(1, 5, 32'hDEADBEEF, 0, 0, 0,    0, 0,  0, 1, 0,  0, 0, 0,            0, 0,            0, 0));
      vq.push_back(v(0, 0, 0,            0, 0, 0,    5, 0,  0, 1, 0,  1, 5, 32'hDEADBEEF, 1, 32'hDEADBEEF, 0, 0));
      vq.push_back(v(0, 0, 0,            0, 0, 0,    5, 0,  0, 1, 0,  0, 5, 32'hDEADBEEF, 0, 0,            0, 0));
      vq.push_back(v(1, 7, 32'h70,       1, 3, 32'h11, 0, 0, 0, 1, 0, 0, 5, 32'hDEADBEEF, 0, 0,            0, 0));
      vq.push_back(v(1, 7, 32'h71,       1, 4, 32'h22, 3, 7, 0, 1, 1, 1, 7, 32'h70,       1, 32'h11,       1, 32'h70));
      vq.push_back(v(1, 7, 32'h72,       1, 5, 32'h33, 4, 3, 0, 0, 2, 1, 7, 32'h71,       1, 32'h22,       1, 32'h11));
      vq.push_back(v(1, 7, 32'h73,       0, 0, 0,    0, 0,  0, 0, 2,  1, 7, 32'h72,       0, 0,            0, 0));
      vq.push_back(v(1, 7, 32'h74,       0, 0, 0,    0, 0,  0, 0, 2,  1, 7, 32'h73,       0, 0,            0, 0));
      vq.push_back(v(1, 7, 32'h75,       0, 0, 0,    0, 0,  1, 0, 2,  1, 7, 32'h74,       0, 0,            0, 0));
      vq.push_back(v(1, 7, 32'h75,       0, 0, 0,    3, 4,  0, 1, 1,  1, 3, 32'h11,       1, 32'h11,       1, 32'h22));
      vq.push_back(v(1, 7, 32'h76,       0, 0, 0,    0, 0,  0, 1, 1,  1, 7, 32'h75,       0, 0,            0, 0));
      vq.push_back(v(1, 7, 32'h77,       0, 0, 0,    0, 0,  0, 1, 1,  1, 7, 32'h76,       0, 0,            0, 0));
      vq.push_back(v(1, 7, 32'h78,       0, 0, 0,    0, 0,  0, 1, 1,  1, 7, 32'h77,       0, 0,            0, 0));
      vq.push_back(v(1, 7, 32'h79,       0, 0, 0,    0, 0,  1, 1, 1,  1, 7, 32'h78,       0, 0,            0, 0));
      vq.push_back(v(1, 7, 32'h79,       0, 0, 0,    0, 0,  0, 1, 0,  1, 4, 32'h22,       0, 0,            0, 0));
      vq.push_back(v(0, 0, 0,            0, 0, 0,    0, 0,  0, 1, 0,  1, 7, 32'h79,       0, 0,            0, 0));
      vq.push_back(v(0, 0, 0,            0, 0, 0,    0, 0,  0, 1, 0,  0, 7, 32'h79,       0, 0,            0, 0));
      vq.push_back(v(1, 0, 32'h55,       1, 0, 32'h66, 0, 0, 0, 1, 0, 0, 7, 32'h79,       0, 0,            0, 0));
      vq.push_back(v(1, 0, 32'h55,       1, 0, 32'h66, 0, 0, 0, 1, 0, 0, 7, 32'h79,       0, 0,            0, 0));
      vq.push_back(v(0, 0, 0,            0, 0, 0,    0, 0,  0, 1, 0,  0, 7, 32'h79,       0, 0,            0, 0));
      vq.push_back(v(0, 0, 0,            1, 9, 32'hA, 0, 0, 0, 1, 0,  0, 7, 32'h79,       0, 0,            0, 0));
      vq.push_back(v(1, 8, 32'h80,       1, 9, 32'hB, 9, 0, 0, 1, 1,  0, 7, 32'h79,       1, 32'hA,        0, 0));
      vq.push_back(v(1, 8, 32'h81,       0, 0, 0,    9, 0,  0, 0, 2,  1, 8, 32'h80,       1, 32'hB,        0, 0));
      vq.push_back(v(0, 0, 0,            0, 0, 0,    8, 9,  0, 0, 2,  1, 8, 32'h81,       1, 32'h81,       1, 32'hB));
      vq.push_back(v(0, 0, 0,            0, 0, 0,    9, 8,  0, 1, 1,  1, 9, 32'hA,        1, 32'hB,        0, 0));
      vq.push_back(v(0, 0, 0,            0, 0, 0,    9, 0,  0, 1, 0,  1, 9, 32'hB,        1, 32'hB,        0, 0));
      vq.push_back(v(0, 0, 0,            0, 0, 0,    9, 0,  0, 1, 0,  0, 9, 32'hB,        0, 0,            0, 0));

      @(negedge clock);
      @(negedge clock);
      ctrl_reset = 1'b0;

      for (int i = 0; i < vq.size(); i++) begin
         t = vq[i];
         drive(t.av, t.ard, t.adat, t.mv, t.mrd, t.mdat, t.fa, t.fb);
         #2;
         chk("alu_stall",        i, 32'(wb.alu_stall),        32'(t.stall));
         chk("md_ready",         i, 32'(wb.md_ready),         32'(t.rdy));
         chk("pending_count",    i, 32'(wb.pending_count),    32'(t.cnt));
         chk("ctrl_writeEnable", i, 32'(wb.ctrl_writeEnable), 32'(t.we));
         chk("ctrl_writeReg",    i, 32'(wb.ctrl_writeReg),    32'(t.wreg));
         chk("data_writeReg",    i, wb.data_writeReg,         t.wdat);
         chk("fwd_hitA",         i, 32'(wb.fwd_hitA),         FWD ? 32'(t.ha) : 32'd0);
         chk("fwd_dataA",        i, wb.fwd_dataA,             FWD ? t.da : 32'd0);
         chk("fwd_hitB",         i, 32'(wb.fwd_hitB),         FWD ? 32'(t.hb) : 32'd0);
         chk("fwd_dataB",        i, wb.fwd_dataB,             FWD ? t.db : 32'd0);
         @(negedge clock);
      end

      // Fill the FIFO behind a busy ALU, then reset between edges.
      drive(1, 7, 32'h90, 1, 3, 32'h11, 7, 0);
      @(negedge clock);
      drive(1, 7, 32'h91, 1, 4, 32'h22, 7, 0);
      @(negedge clock);
      drive(1, 7, 32'h92, 1, 5, 32'h33, 7, 0);
      #2;
      chk("pre_reset_count", 100, 32'(wb.pending_count),    32'd2);
      chk("pre_reset_we",    100, 32'(wb.ctrl_writeEnable), 32'd1);
      chk("pre_reset_hitA",  100, 32'(wb.fwd_hitA),         FWD ? 32'd1 : 32'd0);
      ctrl_reset = 1'b1;
      #1;
      chk("rst_we",      101, 32'(wb.ctrl_writeEnable), 32'd0);
      chk("rst_wreg",    101, 32'(wb.ctrl_writeReg),    32'd0);
      chk("rst_wdata",   101, wb.data_writeReg,         32'd0);
      chk("rst_count",   101, 32'(wb.pending_count),    32'd0);
      chk("rst_ready",   101, 32'(wb.md_ready),         32'd1);
      chk("rst_stall",   101, 32'(wb.alu_stall),        32'd0);
      chk("rst_hitA",    101, 32'(wb.fwd_hitA),         32'd0);
      chk("rst_dataA",   101, wb.fwd_dataA,             32'd0);
      @(negedge clock);
      ctrl_reset = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 3, 4);
      for (int k = 0; k < 4; k++) begin
         #2;
         chk("post_rst_we",    102 + k, 32'(wb.ctrl_writeEnable), 32'd0);
         chk("post_rst_count", 102 + k, 32'(wb.pending_count),    32'd0);
         chk("post_rst_hitA",  102 + k, 32'(wb.fwd_hitA),         32'd0);
         @(negedge clock);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
